// File: rtl/eth_pkg.sv
// eth_pkg: shared constants for the RMII receive path.
// Frame limits, header sizes and frame-buffer FSM encodings.
package eth_pkg;

    localparam int ETH_MIN_FRAME  = 64;
    localparam int ETH_MAX_FRAME  = 1518;
    localparam int ETH_MAC_BYTES  = 6;
    localparam int ETH_TYPE_BYTES = 2;
    localparam int ETH_HDR_BYTES  = 14;
    localparam int ETH_FCS_BYTES  = 4;

    localparam logic [1:0] W_IDLE = 2'h0;
    localparam logic [1:0] W_FILL = 2'h1;
    localparam logic [1:0] W_DROP = 2'h2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_OUT  = 1'b1;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_rx_frame_buf_if.sv
// eth_rx_frame_buf_if: receive byte stream in, committed frames out.
// master = stream source / frame consumer, slave = frame buffer.
interface eth_rx_frame_buf_if;

    logic        Rx_Sof;
    logic        Rx_Byte_Vld;
    logic [7:0]  Rx_Byte;
    logic        Rx_Eof;
    logic        Rx_Crc_Ok;
    logic        Out_Vld;
    logic [7:0]  Out_Data;
    logic        Out_Last;
    logic        Out_Rdy;
    logic [10:0] Out_Len;

    modport master (
        output Rx_Sof, Rx_Byte_Vld, Rx_Byte, Rx_Eof, Rx_Crc_Ok, Out_Rdy,
        input  Out_Vld, Out_Data, Out_Last, Out_Len
    );

    modport slave (
        input  Rx_Sof, Rx_Byte_Vld, Rx_Byte, Rx_Eof, Rx_Crc_Ok, Out_Rdy,
        output Out_Vld, Out_Data, Out_Last, Out_Len
    );

endinterface

// File: rtl/eth_rx_frame_ram.sv
// eth_rx_frame_ram: simple dual-port byte RAM holding both frame slots.
// Synchronous write, registered read with read enable.
module eth_rx_frame_ram #(
    parameter int pAddr_W = 12
) (
    input  logic               Clk,
    input  logic               WrEn,
    input  logic [pAddr_W-1:0] WrAddr,
    input  logic [7:0]         WrData,
    input  logic               RdEn,
    input  logic [pAddr_W-1:0] RdAddr,
    output logic [7:0]         RdData
);

    logic [7:0] mem [2**pAddr_W];

    always_ff @(posedge Clk) begin
        if (WrEn) mem[WrAddr] <= WrData;
        if (RdEn) RdData <= mem[RdAddr];
    end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// eth_rx_frame_buf: two-slot receive frame buffer with FCS/length gating,
// in-order frame streaming and saturating accept/drop counters.
module eth_rx_frame_buf
    import eth_pkg::*;
#(
    parameter int pSlot_Bytes      = 2048,
    parameter int pMin_Frame_Bytes = ETH_MIN_FRAME,
    parameter int pMax_Frame_Bytes = ETH_MAX_FRAME
) (
    input  logic               Clk,
    input  logic               Rst,
    eth_rx_frame_buf_if.slave  bus,
    output logic [15:0]        Frm_Cnt,
    output logic [15:0]        Drop_Cnt
);

    localparam int          OFS_W   = $clog2(pSlot_Bytes);
    localparam logic [10:0] MIN_LEN = 11'(pMin_Frame_Bytes);
    localparam logic [10:0] MAX_LEN = 11'(pMax_Frame_Bytes);

    logic [1:0]  wrState;
    logic        wrSlot;
    logic [10:0] wrCnt;
    logic [1:0]  full;
    logic [10:0] slotLen [2];
    logic        rdState;
    logic        rdSlot;
    logic [10:0] rdPtr;
    logic        outVld;
    logic        outLast;
    logic [10:0] outLen;
    logic [7:0]  ramQ;
    logic        wrEn;
    logic        rdEn;
    logic [OFS_W-1:0] rdOfs;
    logic        commit;
    logic        dropEvt;
    logic        frmDone;

    assign wrEn = (wrState == W_FILL) && bus.Rx_Byte_Vld
                  && !bus.Rx_Sof && (wrCnt != MAX_LEN);
    assign commit = (wrState == W_FILL) && bus.Rx_Eof && !bus.Rx_Sof
                    && bus.Rx_Crc_Ok && (wrCnt >= MIN_LEN);
    // A new Sof aborts whatever frame is in progress.
    assign dropEvt = bus.Rx_Sof ? (wrState != W_IDLE)
                   : (bus.Rx_Eof && (wrState != W_IDLE) && !commit);
    assign frmDone = outVld && bus.Out_Rdy && outLast;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wrState <= W_IDLE;
            wrSlot  <= 1'b0;
            wrCnt   <= '0;
        end else if (bus.Rx_Sof) begin
            wrCnt   <= '0;
            wrState <= full[wrSlot] ? W_DROP : W_FILL;
        end else begin
            unique case (wrState)
                W_FILL: begin
                    if (bus.Rx_Eof) begin
                        wrState <= W_IDLE;
                    end else if (bus.Rx_Byte_Vld) begin
                        if (wrCnt == MAX_LEN) wrState <= W_DROP;
                        else wrCnt <= wrCnt + 11'd1;
                    end
                end
                W_DROP: if (bus.Rx_Eof) wrState <= W_IDLE;
                default: wrState <= W_IDLE;
            endcase
            if (commit) wrSlot <= ~wrSlot;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            full <= '0;
        end else begin
            if (commit) begin
                full[wrSlot]    <= 1'b1;
                slotLen[wrSlot] <= wrCnt;
            end
            if (frmDone) full[rdSlot] <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Frm_Cnt  <= '0;
            Drop_Cnt <= '0;
        end else begin
            if (commit)  Frm_Cnt  <= satInc(Frm_Cnt);
            if (dropEvt) Drop_Cnt <= satInc(Drop_Cnt);
        end
    end

    // Fetch only when the presented byte is consumed; the RAM output
    // register then doubles as the hold register during stalls.
    always_comb begin
        rdEn  = 1'b0;
        rdOfs = '0;
        unique case (rdState)
            R_IDLE: rdEn = full[rdSlot];
            R_OUT: begin
                rdEn  = outVld && bus.Out_Rdy && !outLast;
                rdOfs = OFS_W'(rdPtr);
            end
            default: rdEn = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rdState <= R_IDLE;
            rdSlot  <= 1'b0;
            rdPtr   <= '0;
            outVld  <= 1'b0;
            outLast <= 1'b0;
            outLen  <= '0;
        end else begin
            unique case (rdState)
                R_IDLE: begin
                    if (full[rdSlot]) begin
                        rdState <= R_OUT;
                        outVld  <= 1'b1;
                        outLen  <= slotLen[rdSlot];
                        outLast <= (slotLen[rdSlot] == 11'd1);
                        rdPtr   <= 11'd1;
                    end
                end
                R_OUT: begin
                    if (outVld && bus.Out_Rdy) begin
                        if (outLast) begin
                            rdState <= R_IDLE;
                            outVld  <= 1'b0;
                            outLast <= 1'b0;
                            rdSlot  <= ~rdSlot;
                        end else begin
                            rdPtr   <= rdPtr + 11'd1;
                            outLast <= (rdPtr == outLen - 11'd1);
                        end
                    end
                end
                default: rdState <= R_IDLE;
            endcase
        end
    end

    assign bus.Out_Vld  = outVld;
    assign bus.Out_Data = outVld ? ramQ : 8'h00;
    assign bus.Out_Last = outLast;
    assign bus.Out_Len  = outLen;

    eth_rx_frame_ram #(
        .pAddr_W (OFS_W + 1)
    ) u_ram (
        .Clk    (Clk),
        .WrEn   (wrEn),
        .WrAddr ({wrSlot, OFS_W'(wrCnt)}),
        .WrData (bus.Rx_Byte),
        .RdEn   (rdEn),
        .RdAddr ({rdSlot, rdOfs}),
        .RdData (ramQ)
    );

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Bench for eth_rx_frame_buf: vector table, corner sequences and a
// randomized run against a frame-level commit/drop model.
module tb_eth_rx_frame_buf;

    typedef struct {
        int len;
        bit crc;
        int nOut;
        int frm;
        int drop;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [15:0] Frm_Cnt;
    logic [15:0] Drop_Cnt;

    eth_rx_frame_buf_if bus ();

    eth_rx_frame_buf dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .bus      (bus),
        .Frm_Cnt  (Frm_Cnt),
        .Drop_Cnt (Drop_Cnt)
    );

    always #5 Clk = ~Clk;

    int nChk = 0;
    int nPass = 0;
    int monErr = 0;
    int rdyMode = 1;
    logic [7:0] rxBytes[$];
    logic [7:0] expBytes[$];
    int rxLens[$];
    int expLens[$];

    always @(posedge Clk) begin
        #1;
        if (rdyMode == 2) bus.Out_Rdy = 1'($urandom_range(0, 1));
        else bus.Out_Rdy = (rdyMode != 0);
    end

    // Output monitor: collects frames, checks hold-while-stalled,
    // no mid-frame Out_Vld drop and Out_Len against the byte count.
    int curN = 0;
    logic stall = 1'b0;
    logic [7:0] pData;
    logic pLast;
    logic [10:0] pLen;
    always @(negedge Clk) begin
        if (Rst) begin
            curN = 0;
            stall = 1'b0;
        end else begin
            if (stall && (bus.Out_Vld !== 1'b1 || bus.Out_Data !== pData ||
                          bus.Out_Last !== pLast || bus.Out_Len !== pLen))
                monErr++;
            if (curN > 0 && bus.Out_Vld !== 1'b1) monErr++;
            if (bus.Out_Vld === 1'b1 && bus.Out_Rdy === 1'b1) begin
                rxBytes.push_back(bus.Out_Data);
                curN++;
                if (bus.Out_Last === 1'b1) begin
                    if (32'(bus.Out_Len) != curN) monErr++;
                    rxLens.push_back(curN);
                    curN = 0;
                end
            end
            stall = (bus.Out_Vld === 1'b1) && (bus.Out_Rdy !== 1'b1);
            pData = bus.Out_Data;
            pLast = bus.Out_Last;
            pLen  = bus.Out_Len;
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic sof();
        bus.Rx_Sof = 1'b1;
        tick();
        bus.Rx_Sof = 1'b0;
    endtask

    task automatic sendBytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            bus.Rx_Byte_Vld = 1'b1;
            bus.Rx_Byte = base + 8'(i);
            tick();
        end
        bus.Rx_Byte_Vld = 1'b0;
    endtask

    task automatic eof(input bit crc);
        bus.Rx_Eof = 1'b1;
        bus.Rx_Crc_Ok = crc;
        tick();
        bus.Rx_Eof = 1'b0;
        bus.Rx_Crc_Ok = 1'b0;
    endtask

    task automatic sendFrame(input int n, input bit crc,
                             input logic [7:0] base, input bit expOut);
        sof();
        sendBytes(n, base);
        eof(crc);
        if (expOut) begin
            for (int i = 0; i < n; i++) expBytes.push_back(base + 8'(i));
            expLens.push_back(n);
        end
    endtask

    task automatic waitDrain();
        int idle = 0;
        int t = 0;
        while (idle < 4 && t < 20000) begin
            @(negedge Clk);
            idle = (bus.Out_Vld === 1'b1) ? 0 : idle + 1;
            t++;
        end
        tick();
        check("drain_done", 32'(idle >= 4), 1);
    endtask

    task automatic clearQ();
        rxBytes.delete();
        rxLens.delete();
        expBytes.delete();
        expLens.delete();
        monErr = 0;
    endtask

    task automatic resetDut();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        clearQ();
    endtask

    task automatic cmpFrames(input string name);
        int err = 0;
        check({name, "_frames"}, rxLens.size(), expLens.size());
        for (int i = 0; i < expLens.size() && i < rxLens.size(); i++)
            if (rxLens[i] != expLens[i]) err++;
        for (int i = 0; i < expBytes.size(); i++)
            if (i >= rxBytes.size() || rxBytes[i] !== expBytes[i]) err++;
        if (rxBytes.size() != expBytes.size()) err++;
        check({name, "_data"}, err, 0);
        check({name, "_mon"}, monErr, 0);
        clearQ();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int lat;
        int cyc;
        int len;
        int eFrm;
        int eDrop;
        bit crc;
        bit ok;

        bus.Rx_Sof = 1'b0;
        bus.Rx_Byte_Vld = 1'b0;
        bus.Rx_Byte = 8'h00;
        bus.Rx_Eof = 1'b0;
        bus.Rx_Crc_Ok = 1'b0;
        Rst = 1'b1;
        repeat (3) tick();
        check("rst_vld", bus.Out_Vld, 0);
        check("rst_last", bus.Out_Last, 0);
        check("rst_data", bus.Out_Data, 0);
        check("rst_len", bus.Out_Len, 0);
        check("rst_frm", Frm_Cnt, 0);
        check("rst_drop", Drop_Cnt, 0);
        Rst = 1'b0;
        tick();

        // Good 64-byte frame: latency, bubble-free burst, length.
        rdyMode = 1;
        sendFrame(64, 1'b1, 8'h00, 1'b1);
        lat = 1;
        @(negedge Clk);
        while (bus.Out_Vld !== 1'b1 && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        check("t1_latency", lat, 2);
        cyc = 1;
        while (bus.Out_Last !== 1'b1 && cyc < 200) begin
            @(negedge Clk);
            cyc++;
        end
        check("t1_burst", cyc, 64);
        check("t1_len", bus.Out_Len, 64);
        check("t1_lastbyte", bus.Out_Data, 8'h3F);
        tick();
        waitDrain();
        check("t1_frm", Frm_Cnt, 1);
        check("t1_drop", Drop_Cnt, 0);
        cmpFrames("t1");

        vt = '{'{64, 1'b0, 0, 0, 1}, '{60, 1'b1, 0, 0, 2},
               '{64, 1'b1, 1, 1, 2}, '{63, 1'b1, 0, 1, 3},
               '{1518, 1'b1, 1, 2, 3}, '{1519, 1'b1, 0, 2, 4},
               '{1600, 1'b1, 0, 2, 5}, '{64, 1'b1, 1, 3, 5}};
        resetDut();
        for (int i = 0; i < 8; i++) begin
            sendFrame(vt[i].len, vt[i].crc, 8'(i * 16), vt[i].nOut != 0);
            waitDrain();
            check($sformatf("vec%0d_nout", i), rxLens.size(), vt[i].nOut);
            check($sformatf("vec%0d_frm", i), Frm_Cnt, vt[i].frm);
            check($sformatf("vec%0d_drop", i), Drop_Cnt, vt[i].drop);
            cmpFrames($sformatf("vec%0d", i));
        end

        // Both slots filled while stalled; third frame finds no room.
        resetDut();
        rdyMode = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            sendFrame(100, 1'b1, 8'(k * 50 + 1), k < 2);
            repeat (5) tick();
        end
        check("bp_drop", Drop_Cnt, 1);
        check("bp_frm", Frm_Cnt, 2);
        @(negedge Clk);
        check("bp_vld", bus.Out_Vld, 1);
        check("bp_hold", bus.Out_Data, 1);
        tick();
        rdyMode = 1;
        waitDrain();
        cmpFrames("bp");

        // Truncated frame followed by a good one.
        resetDut();
        sof();
        sendBytes(30, 8'hA0);
        sendFrame(64, 1'b1, 8'h40, 1'b1);
        waitDrain();
        check("trunc_drop", Drop_Cnt, 1);
        check("trunc_frm", Frm_Cnt, 1);
        cmpFrames("trunc");

        // Random backpressure over a 200-byte frame.
        rdyMode = 2;
        sendFrame(200, 1'b1, 8'h11, 1'b1);
        waitDrain();
        check("stall_frm", Frm_Cnt, 2);
        cmpFrames("stall");

        // Reset in the middle of output.
        sendFrame(200, 1'b1, 8'h22, 1'b0);
        repeat (40) tick();
        check("mid_vld", bus.Out_Vld, 1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("rstmid_vld", bus.Out_Vld, 0);
        check("rstmid_frm", Frm_Cnt, 0);
        check("rstmid_drop", Drop_Cnt, 0);
        clearQ();
        waitDrain();
        cmpFrames("rstmid");

        // Randomized frames against the commit rule.
        resetDut();
        rdyMode = 2;
        eFrm = 0;
        eDrop = 0;
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: len = 63;
                    1: len = 64;
                    2: len = 1518;
                    default: len = 1519;
                endcase
            end else begin
                len = $urandom_range(40, 260);
            end
            crc = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                sof();
                sendBytes($urandom_range(1, 50), 8'h5A);
                eDrop++;
            end
            ok = crc && len >= 64 && len <= 1518;
            if (ok) eFrm++;
            else eDrop++;
            sendFrame(len, crc, 8'($urandom), ok);
            waitDrain();
        end
        check("rand_frm", Frm_Cnt, eFrm);
        check("rand_drop", Drop_Cnt, eDrop);
        cmpFrames("rand");

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_buf.md
# eth_rx_frame_buf

Receive-side frame controller that sits directly after the RMII receive datapath. It captures the byte stream of each incoming frame into one of two frame slots and commits a frame only if its FCS checked good and its length is legal. It streams committed frames in arrival order to the downstream consumer over a valid/ready handshake, and keeps drop and accept statistics.

## Interface
- pSlot_Bytes, 2048, bytes per slot; power of two, must be ≥ pMax_Frame_Bytes
- pMin_Frame_Bytes, 64, minimum legal length (DA through FCS inclusive)
- pMax_Frame_Bytes, 1518, maximum legal length (DA through FCS inclusive)
- Clk  in  1  single clock (RMII 50 MHz domain)
- Rst  in  1  synchronous, active-high reset
- Rx_Sof  in  1  one-cycle pulse: a new frame starts; no byte on this cycle
- Rx_Byte_Vld  in  1  Rx_Byte is a frame byte (DA first, FCS last)
- Rx_Byte  in  8  received byte
- Rx_Eof  in  1  one-cycle pulse after the final byte; no byte on this cycle
- Rx_Crc_Ok  in  1  FCS result; sampled only when Rx_Eof=1
- Out_Vld  out  1  Out_Data holds a frame byte
- Out_Data  out  8  frame byte, DA first
- Out_Last  out  1  last byte of the frame (FCS byte 4)
- Out_Rdy  in  1  consumer accepts the byte when Out_Vld&Out_Rdy
- Out_Len  out  11  committed length of the frame being output; valid while Out_Vld
- Frm_Cnt  out  16  frames committed; saturates at 0xFFFF
- Drop_Cnt  out  16  frames dropped; saturates at 0xFFFF

## Operation
- Two slots (0,1) with per-slot full flag and 11-bit length. wr_slot and rd_slot both reset to 0 and toggle independently.
- Write FSM states:
  - W_IDLE → on Rx_Sof: go to W_FILL if slot[wr_slot] is not full, else go to W_DROP.
  - W_FILL: each Rx_Byte_Vld writes slot[wr_slot][wr_cnt] and increments wr_cnt. When wr_cnt reaches pMax_Frame_Bytes and another byte arrives, go to W_DROP.
  - W_FILL + Rx_Eof: commit if Rx_Crc_Ok=1 and wr_cnt≥pMin_Frame_Bytes. Commit sets full, latches length=wr_cnt, toggles wr_slot and increments Frm_Cnt. Otherwise Drop_Cnt++ and the slot stays free. Return to W_IDLE in both cases.
  - W_DROP: ignore bytes. On Rx_Eof: Drop_Cnt++, go to W_IDLE.
  - Rx_Sof while in W_FILL or W_DROP (truncated frame): Drop_Cnt++ for the old frame, then handle the new Sof exactly as in W_IDLE on the same cycle.
  - Rx_Eof in W_IDLE is ignored.
  - wr_cnt clears on every Sof.
- Read FSM states:
  - R_IDLE → R_OUT when slot[rd_slot] is full.
  - R_OUT: presents bytes 0..len-1 in order.
  - On the handshake of the Out_Last byte: clear slot[rd_slot].full, toggle rd_slot, go to R_IDLE.
- Out_Data, Out_Last and Out_Len stay stable while Out_Vld=1 and Out_Rdy=0. Out_Vld never drops mid-frame.
- Reset values: Out_Vld=0, Out_Last=0, Out_Data=0, Out_Len=0, Frm_Cnt=0, Drop_Cnt=0, both full flags=0, FSMs in W_IDLE/R_IDLE.
- Reset mid-frame discards the partial frame and any committed frames. No counter increments for them.

## Timing
- Commit occurs at the clock edge where Rx_Eof=1. The full flag is visible on the next cycle.
- First Out_Vld asserts 2 cycles after the Rx_Eof cycle (1 cycle flag visibility + 1-cycle RAM read).
- With Out_Rdy held high: one byte per cycle, no bubbles, through Out_Last.
- A slot freed by the Out_Last handshake on cycle N is usable by an Rx_Sof on cycle N+1 or later. Rx_Sof on cycle N sees the slot full.
- Committing slot A and releasing slot B on the same cycle are independent. Both take effect.
- Commit and read of the same slot never overlap: the full flag gates both sides.
- Counters update on the cycle after the deciding event and saturate (no wrap).

## Structure
- eth_pkg holds:
  - pMin_Frame_Bytes and pMax_Frame_Bytes defaults
  - write FSM encodings (W_IDLE=2'h0, W_FILL=2'h1, W_DROP=2'h2)
  - read FSM encodings (R_IDLE=1'b0, R_OUT=1'b1)
  - header byte counts already used by the receive path
- Sub-module eth_rx_frame_ram:
  - simple dual-port RAM, depth 2×pSlot_Bytes × 8 bits
  - address = {slot, offset}
  - synchronous write, registered 1-cycle read
- Write FSM, read FSM with output hold/skid register, and counters live in eth_rx_frame_buf.

## Test plan
- Good 64-byte frame (bytes 0x00..0x3F), Crc_Ok=1, Out_Rdy=1 → 64 bytes out in order, Out_Last on 0x3F, Out_Len=64, Frm_Cnt=1, first Out_Vld 2 cycles after Eof.
- Same frame with Crc_Ok=0, then a 60-byte frame with Crc_Ok=1 → no Out_Vld, Drop_Cnt=2, Frm_Cnt=0.
- Out_Rdy=0 held; send three good 100-byte frames → frames 1,2 stored, frame 3 dropped (Drop_Cnt=1). Then Out_Rdy=1 → frames 1 then 2 output intact.
- 1600-byte frame with Crc_Ok=1 → dropped (Drop_Cnt=1); the following 64-byte good frame is output correctly.
- Rx_Sof after 30 bytes of a frame, then a full 64-byte good frame → Drop_Cnt=1, Frm_Cnt=1, output equals the second frame.
- Random Out_Rdy toggling over a 200-byte frame → Out_Data stable while stalled, all 200 bytes in order. Rst asserted mid-output → Out_Vld=0 on the next cycle, counters=0.
